// File: rtl/mem_responder.sv
// Memory-side responder for the MFA/MFC handshake: byte/halfword/word access to a
// big-endian byte RAM after WAIT_CYCLES wait states. Optional macro: MEM_ALIGN_CHECK_EN.
module mem_responder #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              mfa,
  input  logic              rw,
  input  logic [1:0]        mas,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       data_in,
  output logic [31:0]       data_out,
  output logic              mfc,
  output logic              err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam int DEPTH = 1 << ADDR_W;

  logic [1:0]        r_state;
  logic [3:0]        r_cnt;
  logic              r_rw;
  logic [1:0]        r_mas;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_dout;
  logic              r_mfc;
  logic              r_err;
  logic [7:0]        r_mem [0:DEPTH-1];

  logic              w_byte, w_half, w_word, w_mis, w_commit;
  logic [ADDR_W-1:0] w_a0, w_a1, w_a2, w_a3;
  logic [31:0]       w_rdata;

  assign w_byte = (r_mas == 2'b00);
  assign w_half = (r_mas == 2'b10);
  assign w_word = !w_byte && !w_half;

`ifdef MEM_ALIGN_CHECK_EN
  assign w_mis = (w_half && r_addr[0]) || (w_word && (r_addr[1:0] != 2'b00));
`else
  assign w_mis = 1'b0;
`endif

  // Halfword/word effective addresses are aligned, so a+k is just a|k.
  always_comb begin
    w_a0 = r_addr;
    if (w_half) w_a0[0] = 1'b0;
    if (w_word) w_a0[1:0] = 2'b00;
  end
  assign w_a1 = w_a0 | ADDR_W'(1);
  assign w_a2 = w_a0 | ADDR_W'(2);
  assign w_a3 = w_a0 | ADDR_W'(3);

  always_comb begin
    w_rdata = {24'b0, r_mem[w_a0]};
    if (w_half) w_rdata = {16'b0, r_mem[w_a0], r_mem[w_a1]};
    if (w_word) w_rdata = {r_mem[w_a0], r_mem[w_a1], r_mem[w_a2], r_mem[w_a3]};
  end

  // clr gates the write so an access interrupted in WAIT never reaches the RAM.
  assign w_commit = (r_state == S_WAIT) && (r_cnt == 4'd0) && !clr;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_rw    <= 1'b0;
      r_mas   <= 2'b00;
      r_addr  <= '0;
      r_wdata <= 32'd0;
      r_dout  <= 32'd0;
      r_mfc   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (mfa) begin
          r_rw    <= rw;
          r_mas   <= mas;
          r_addr  <= addr;
          r_wdata <= data_in;
          r_cnt   <= 4'(WAIT_CYCLES);
          r_state <= S_WAIT;
        end
        S_WAIT: if (r_cnt != 4'd0) begin
          r_cnt <= r_cnt - 4'd1;
        end else begin
          r_mfc   <= 1'b1;
          r_err   <= w_mis;
          if (!r_rw && !w_mis) r_dout <= w_rdata;
          r_state <= S_DONE;
        end
        S_DONE: if (!mfa) begin
          r_mfc   <= 1'b0;
          r_err   <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_commit && r_rw && !w_mis) begin
      if (w_byte) begin
        r_mem[w_a0] <= r_wdata[7:0];
      end else if (w_half) begin
        r_mem[w_a0] <= r_wdata[15:8];
        r_mem[w_a1] <= r_wdata[7:0];
      end else begin
        r_mem[w_a0] <= r_wdata[31:24];
        r_mem[w_a1] <= r_wdata[23:16];
        r_mem[w_a2] <= r_wdata[15:8];
        r_mem[w_a3] <= r_wdata[7:0];
      end
    end
  end

  assign data_out = r_dout;
  assign mfc      = r_mfc;
  assign err      = r_err;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder against a byte-array reference model;
// a second instance with zero wait states covers the minimum-latency case.
module tb_mem_responder;
  localparam int AW = 8;
  localparam int WC = 2;
`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          clr, mfa, rw;
  logic [1:0]    mas;
  logic [AW-1:0] addr;
  logic [31:0]   data_in, data_out;
  logic          mfc, err;
  logic          mfa0, rw0;
  logic [1:0]    mas0;
  logic [AW-1:0] addr0;
  logic [31:0]   data_in0, data_out0;
  logic          mfc0, err0;

  mem_responder #(.ADDR_W(AW), .WAIT_CYCLES(WC)) u_dut (
    .clk(clk), .clr(clr), .mfa(mfa), .rw(rw), .mas(mas), .addr(addr),
    .data_in(data_in), .data_out(data_out), .mfc(mfc), .err(err));

  mem_responder #(.ADDR_W(AW), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .clr(clr), .mfa(mfa0), .rw(rw0), .mas(mas0), .addr(addr0),
    .data_in(data_in0), .data_out(data_out0), .mfc(mfc0), .err(err0));

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_err = 0;
  logic [7:0]  ref_mem [256];
  logic [31:0] exp_dout;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Reference: size in bytes, aligned base, big-endian byte order.
  task automatic model(input logic r, input logic [1:0] m, input logic [7:0] a,
                       input logic [31:0] d, output logic mis);
    int sz, base;
    sz   = (m == 2'b00) ? 1 : (m == 2'b10) ? 2 : 4;
    base = int'(a) - (int'(a) % sz);
    mis  = ALIGN && ((int'(a) % sz) != 0);
    if (!mis) begin
      if (r) begin
        for (int k = 0; k < sz; k++) ref_mem[base+k] = 8'(d >> (8 * (sz - 1 - k)));
      end else begin
        exp_dout = 32'd0;
        for (int k = 0; k < sz; k++) exp_dout = (exp_dout << 8) | 32'(ref_mem[base+k]);
      end
    end
  endtask

  task automatic access(input logic r, input logic [1:0] m, input logic [7:0] a,
                        input logic [31:0] d, input int hold, input bit drop_early,
                        output logic [31:0] got);
    logic mis;
    int   n;
    @(negedge clk);
    rw = r; mas = m; addr = a; data_in = d; mfa = 1'b1;
    @(posedge clk);
    model(r, m, a, d, mis);
    @(negedge clk);
    rw = ~r; mas = 2'($urandom); addr = 8'($urandom); data_in = $urandom;
    if (drop_early) mfa = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!mfc && n < 40);
    chk("latency", n, WC + 1);
    chk("data_out", data_out, exp_dout);
    chk("err", 32'(err), 32'(mis));
    got = data_out;
    if (!drop_early) begin
      repeat (hold) begin
        @(posedge clk); #1;
        chk("mfc_hold", 32'(mfc), 1);
      end
      @(negedge clk);
      mfa = 1'b0;
    end
    @(posedge clk); #1;
    chk("mfc_off", 32'(mfc), 0);
    chk("err_off", 32'(err), 0);
  endtask

  initial begin
    logic [31:0] got, pre;
    clr = 1'b1; mfa = 1'b0; rw = 1'b0; mas = 2'b00; addr = '0; data_in = '0;
    mfa0 = 1'b0; rw0 = 1'b0; mas0 = 2'b00; addr0 = '0; data_in0 = '0;
    exp_dout = 32'd0;
    #12;
    chk("rst_mfc", 32'(mfc), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_dout", data_out, 0);
    @(negedge clk); clr = 1'b0;

    for (int i = 0; i < 64; i++) access(1'b1, 2'b01, 8'(i * 4), $urandom, 0, 1'b0, got);

    access(1'b1, 2'b01, 8'h10, 32'hDEADBEEF, 0, 1'b0, got);
    access(1'b0, 2'b01, 8'h10, 32'h0, 1, 1'b0, got);
    chk("tp_w10", got, 32'hDEADBEEF);
    access(1'b0, 2'b00, 8'h11, 32'h0, 0, 1'b0, got);
    chk("tp_b11", got, 32'h000000AD);
    access(1'b0, 2'b10, 8'h12, 32'h0, 0, 1'b0, got);
    chk("tp_h12", got, 32'h0000BEEF);
    access(1'b1, 2'b00, 8'h13, 32'hFFFFFF5A, 0, 1'b0, got);
    access(1'b0, 2'b11, 8'h10, 32'h0, 2, 1'b0, got);
    chk("tp_w10b", got, 32'hDEADBE5A);

    // Reset in the middle of a write's wait states.
    @(negedge clk);
    rw = 1'b1; mas = 2'b01; addr = 8'h20; data_in = 32'h12345678; mfa = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr = 1'b1; #1;
    chk("clr_mfc", 32'(mfc), 0);
    chk("clr_dout", data_out, 0);
    exp_dout = 32'd0;
    mfa = 1'b0;
    @(posedge clk);
    @(negedge clk); clr = 1'b0;
    access(1'b0, 2'b01, 8'h20, 32'h0, 0, 1'b0, got);

    // Misaligned word write.
    pre = {ref_mem[8'h30], ref_mem[8'h31], ref_mem[8'h32], ref_mem[8'h33]};
    access(1'b1, 2'b01, 8'h33, 32'hCAFEF00D, 0, 1'b0, got);
    access(1'b0, 2'b01, 8'h30, 32'h0, 0, 1'b0, got);
`ifdef MEM_ALIGN_CHECK_EN
    chk("mis_rd30", got, pre);
`else
    chk("mis_rd30", got, 32'hCAFEF00D);
`endif

    access(1'b0, 2'b10, 8'h12, 32'h0, 0, 1'b1, got);

    // Zero-wait instance: mfa high for four sampled edges.
    @(negedge clk);
    mfa0 = 1'b1; rw0 = 1'b1; mas0 = 2'b00; addr0 = 8'h00; data_in0 = 32'h0;
    @(posedge clk); #1;
    chk("wc0_e0", 32'(mfc0), 0);
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      chk("wc0_hi", 32'(mfc0), 1);
    end
    @(negedge clk); mfa0 = 1'b0;
    @(posedge clk); #1;
    chk("wc0_off", 32'(mfc0), 0);

    for (int i = 0; i < 80; i++)
      access(1'($urandom), 2'($urandom), 8'($urandom), $urandom,
             int'($urandom_range(0, 2)), ($urandom_range(0, 3) == 0), got);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
